// File: rtl/tlb_walk_requester.sv
// tlb_walk_requester: single-outstanding page-table walk initiator with bounded retry
// and saturating walk/fault statistics.
module tlb_walk_requester #(
   parameter int VPN_W     = 3,
   parameter int PTE_W     = 6,
   parameter int TIMEOUT   = 15,
   parameter int MAX_RETRY = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MISS_VALID,
   input  logic [VPN_W-1:0] MISS_VPN,
   output logic             MISS_READY,
   output logic             LOOKUP_RQST,
   output logic [VPN_W-1:0] LOOKUP_ADDR,
   input  logic             LOOKUP_COMPLETE,
   input  logic [PTE_W-1:0] LOOKUP_RETURN,
   output logic             FILL_VALID,
   output logic [VPN_W-1:0] FILL_VPN,
   output logic [PTE_W-1:0] FILL_PTE,
   output logic             FILL_FAULT,
   output logic             FILL_TIMEOUT,
   input  logic             FILL_ACK,
   output logic [CNT_W-1:0] WALK_CNT,
   output logic [CNT_W-1:0] FAULT_CNT
);
   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = $clog2(MAX_RETRY + 2);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t           state_q;
   logic [TW-1:0]    timer_q;
   logic [RW-1:0]    retry_q;
   logic             miss_ready_q, lookup_rqst_q, fill_valid_q, fill_fault_q, fill_timeout_q;
   logic [VPN_W-1:0] addr_q;
   logic [PTE_W-1:0] fill_pte_q;
   logic [CNT_W-1:0] walk_cnt_q, fault_cnt_q, walk_cnt_d, fault_cnt_d;
   logic             rsp, expire, give_up, bad_pte;
   always_comb begin
      rsp         = (state_q == ISSUE || state_q == WAIT) && LOOKUP_COMPLETE;
      expire      = state_q == WAIT && !LOOKUP_COMPLETE && timer_q == TW'(TIMEOUT - 1);
      give_up     = expire && retry_q == RW'(MAX_RETRY);
      bad_pte     = ~LOOKUP_RETURN[PTE_W-1];
      walk_cnt_d  = &walk_cnt_q  ? walk_cnt_q  : walk_cnt_q + 1'b1;
      fault_cnt_d = &fault_cnt_q ? fault_cnt_q : fault_cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         retry_q        <= '0;
         miss_ready_q   <= 1'b1;
         lookup_rqst_q  <= 1'b0;
         addr_q         <= '0;
         fill_valid_q   <= 1'b0;
         fill_pte_q     <= '0;
         fill_fault_q   <= 1'b0;
         fill_timeout_q <= 1'b0;
         walk_cnt_q     <= '0;
         fault_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (MISS_VALID) begin
               addr_q        <= MISS_VPN;
               retry_q       <= '0;
               miss_ready_q  <= 1'b0;
               lookup_rqst_q <= 1'b1;
               state_q       <= ISSUE;
            end
            ISSUE, WAIT: begin
               lookup_rqst_q <= 1'b0;
               timer_q       <= state_q == ISSUE ? '0 : timer_q + 1'b1;
               // a completion always beats timer expiry in the same cycle
               if (rsp) begin
                  fill_pte_q     <= LOOKUP_RETURN;
                  fill_fault_q   <= bad_pte;
                  fill_timeout_q <= 1'b0;
                  fill_valid_q   <= 1'b1;
                  walk_cnt_q     <= walk_cnt_d;
                  if (bad_pte) fault_cnt_q <= fault_cnt_d;
                  state_q        <= RESP;
               end else if (give_up) begin
                  fill_pte_q     <= '0;
                  fill_fault_q   <= 1'b1;
                  fill_timeout_q <= 1'b1;
                  fill_valid_q   <= 1'b1;
                  walk_cnt_q     <= walk_cnt_d;
                  fault_cnt_q    <= fault_cnt_d;
                  state_q        <= RESP;
               end else if (expire) begin
                  retry_q       <= retry_q + 1'b1;
                  lookup_rqst_q <= 1'b1;
                  state_q       <= ISSUE;
               end else if (state_q == ISSUE) begin
                  state_q <= WAIT;
               end
            end
            RESP: if (FILL_ACK) begin
               fill_valid_q <= 1'b0;
               miss_ready_q <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign MISS_READY   = miss_ready_q;
   assign LOOKUP_RQST  = lookup_rqst_q;
   assign LOOKUP_ADDR  = addr_q;
   assign FILL_VALID   = fill_valid_q;
   assign FILL_VPN     = addr_q;
   assign FILL_PTE     = fill_pte_q;
   assign FILL_FAULT   = fill_fault_q;
   assign FILL_TIMEOUT = fill_timeout_q;
   assign WALK_CNT     = walk_cnt_q;
   assign FAULT_CNT    = fault_cnt_q;
endmodule

// File: tb/tb_tlb_walk_requester.sv
// tb_tlb_walk_requester: directed vector table plus retry/timeout and race sequences
// for tlb_walk_requester built with TIMEOUT=4, MAX_RETRY=1.
module tb_tlb_walk_requester;
   typedef struct packed {
      logic       rdy, rqst, fv, flt, tmo;
      logic [2:0] addr, fvpn;
      logic [5:0] pte;
      logic [7:0] wc, fc;
   } out_t;
   typedef struct {
      string      name;
      logic       r, m;
      logic [2:0] v;
      logic       c;
      logic [5:0] rt;
      logic       a;
      out_t       exp;
   } vec_t;
   logic       clk = 1'b0, rst, mv, cmp, ack;
   logic [2:0] vpn, addr, fvpn;
   logic [5:0] ret, pte;
   logic       rdy, rqst, fv, flt, tmo;
   logic [7:0] wc, fc;
   int         n_chk = 0, n_fail = 0;
   vec_t       tbl[$];
   int         p[$];
   int         fv_at, extra;
   always #5 clk = ~clk;
   tlb_walk_requester #(.TIMEOUT(4), .MAX_RETRY(1)) dut (
      .clk(clk), .rst(rst), .MISS_VALID(mv), .MISS_VPN(vpn), .MISS_READY(rdy),
      .LOOKUP_RQST(rqst), .LOOKUP_ADDR(addr), .LOOKUP_COMPLETE(cmp), .LOOKUP_RETURN(ret),
      .FILL_VALID(fv), .FILL_VPN(fvpn), .FILL_PTE(pte), .FILL_FAULT(flt),
      .FILL_TIMEOUT(tmo), .FILL_ACK(ack), .WALK_CNT(wc), .FAULT_CNT(fc)
   );
   function automatic out_t o(logic r, q, v, f, t, logic [2:0] a, logic [5:0] pt,
                              logic [7:0] w, c);
      return {r, q, v, f, t, a, a, pt, w, c};
   endfunction
   function automatic out_t obs();
      return {rdy, rqst, fv, flt, tmo, addr, fvpn, pte, wc, fc};
   endfunction
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(logic r, m, logic [2:0] v, logic c, logic [5:0] rt, logic a);
      rst = r; mv = m; vpn = v; cmp = c; ret = rt; ack = a;
      @(posedge clk);
      #1;
   endtask
   task automatic add(string n, logic r, m, logic [2:0] v, logic c, logic [5:0] rt,
                      logic a, out_t e);
      tbl.push_back('{n, r, m, v, c, rt, a, e});
   endtask
   initial begin
      // name, rst, miss_valid, vpn, complete, return, ack, expected outputs after edge
      add("reset",        1, 0, 0, 0, 6'h00, 0, o(1, 0, 0, 0, 0, 0, 6'h00, 0, 0));
      add("t1_accept",    0, 1, 5, 0, 6'h00, 0, o(0, 1, 0, 0, 0, 5, 6'h00, 0, 0));
      add("t1_issue",     0, 1, 2, 0, 6'h00, 0, o(0, 0, 0, 0, 0, 5, 6'h00, 0, 0));
      add("t1_wait",      0, 0, 0, 0, 6'h00, 0, o(0, 0, 0, 0, 0, 5, 6'h00, 0, 0));
      add("t1_complete",  0, 0, 0, 1, 6'h2A, 0, o(0, 0, 1, 0, 0, 5, 6'h2A, 1, 0));
      add("t1_hold",      0, 0, 0, 0, 6'h00, 0, o(0, 0, 1, 0, 0, 5, 6'h2A, 1, 0));
      add("t1_ack",       0, 0, 0, 0, 6'h00, 1, o(1, 0, 0, 0, 0, 5, 6'h2A, 1, 0));
      add("t2_accept",    0, 1, 2, 0, 6'h00, 0, o(0, 1, 0, 0, 0, 2, 6'h2A, 1, 0));
      add("t2_issue",     0, 0, 0, 0, 6'h00, 0, o(0, 0, 0, 0, 0, 2, 6'h2A, 1, 0));
      add("t2_invalid",   0, 0, 0, 1, 6'h0A, 0, o(0, 0, 1, 1, 0, 2, 6'h0A, 2, 1));
      add("t2_ack_stray", 0, 0, 0, 1, 6'h3F, 1, o(1, 0, 0, 1, 0, 2, 6'h0A, 2, 1));
      add("idle_stray",   0, 0, 0, 1, 6'h3F, 0, o(1, 0, 0, 1, 0, 2, 6'h0A, 2, 1));
      add("t4_accept",    0, 1, 7, 0, 6'h00, 0, o(0, 1, 0, 1, 0, 7, 6'h0A, 2, 1));
      add("t4_zero_wait", 0, 0, 0, 1, 6'h31, 0, o(0, 0, 1, 0, 0, 7, 6'h31, 3, 1));
      for (int i = 0; i < 10; i++)
         add($sformatf("t5_hold%0d", i), 0, 1, 3, 1, 6'h15, 0,
             o(0, 0, 1, 0, 0, 7, 6'h31, 3, 1));
      add("t5_ack",       0, 0, 0, 0, 6'h00, 1, o(1, 0, 0, 0, 0, 7, 6'h31, 3, 1));
      add("t6_accept",    0, 1, 4, 0, 6'h00, 0, o(0, 1, 0, 0, 0, 4, 6'h31, 3, 1));
      add("t6_wait",      0, 0, 0, 0, 6'h00, 0, o(0, 0, 0, 0, 0, 4, 6'h31, 3, 1));
      add("t6_reset",     1, 0, 0, 1, 6'h2A, 0, o(1, 0, 0, 0, 0, 0, 6'h00, 0, 0));
      add("t6_accept2",   0, 1, 6, 0, 6'h00, 0, o(0, 1, 0, 0, 0, 6, 6'h00, 0, 0));
      add("t6_complete",  0, 0, 0, 1, 6'h2C, 0, o(0, 0, 1, 0, 0, 6, 6'h2C, 1, 0));
      add("t6_ack",       0, 0, 0, 0, 6'h00, 1, o(1, 0, 0, 0, 0, 6, 6'h2C, 1, 0));
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].c, tbl[i].rt, tbl[i].a);
         check(tbl[i].name, obs(), tbl[i].exp);
      end
      // no reply at all: two attempts 5 cycles apart, then a timeout fill
      step(0, 1, 1, 0, 6'h00, 0);
      fv_at = -1;
      for (int i = 0; i < 20; i++) begin
         if (rqst) p.push_back(i);
         if (fv && fv_at < 0) fv_at = i;
         step(0, 0, 0, 0, 6'h00, 0);
      end
      check("t3_pulse_count", p.size(), 2);
      check("t3_first_pulse", p.size() >= 1 ? p[0] : -1, 0);
      check("t3_spacing", p.size() >= 2 ? p[1] - p[0] : -1, 5);
      check("t3_fill_cycle", fv_at, 10);
      check("t3_timeout_fill", obs(), o(0, 0, 1, 1, 1, 1, 6'h00, 2, 1));
      step(0, 0, 0, 0, 6'h00, 1);
      check("t3_ack", obs(), o(1, 0, 0, 1, 1, 1, 6'h00, 2, 1));
      // reply arrives in the very cycle the timer expires: accepted, no retry
      step(0, 1, 3, 0, 6'h00, 0);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 6'h00, 0);
         if (rqst) extra++;
      end
      step(0, 0, 0, 1, 6'h2A, 0);
      check("race_no_retry", extra, 0);
      check("race_complete", obs(), o(0, 0, 1, 0, 0, 3, 6'h2A, 3, 1));
      step(0, 0, 0, 0, 6'h00, 1);
      // late reply after a retry has been issued is still taken
      step(0, 1, 6, 0, 6'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 6'h00, 0);
      check("retry_reissue", obs(), o(0, 1, 0, 0, 0, 6, 6'h2A, 3, 1));
      step(0, 0, 0, 1, 6'h05, 0);
      check("retry_late_reply", obs(), o(0, 0, 1, 1, 0, 6, 6'h05, 4, 2));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
